zstd_frame_header_parser: RTL and testbench

// - Parses a Zstandard frame header from a little-endian byte stream delivered IN_BYTES per beat.
// - Checks the magic number and extracts FHD, Window_Descriptor, Dictionary_ID and Frame_Content_Size.
// - Returns the trailing bytes of the final beat so the block-header stage can resume mid-beat.
// - Sits between the input DMA/FIFO and the block decoder.

---
 rtl/zstd_frame_header_parser.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_zstd_frame_header_parser.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zstd_frame_header_parser.sv
// ----------------------------------------------------------------------------
// zstd_frame_header_parser
//
// Parses a Zstandard frame header from a little-endian byte stream that
// arrives IN_BYTES bytes per beat. It checks the magic number, extracts the
// Frame_Header_Descriptor, Window_Descriptor, Dictionary_ID and
// Frame_Content_Size, and hands back the unconsumed tail of the final beat
// so the block-header stage can resume mid-beat.
//
// Every byte of a transferred beat is processed in that same cycle. A
// combinational walk steps through the beat byte by byte and may cross
// several field boundaries. Zero-length fields are skipped without using a
// byte.
//
// Optional feature (compile-time macro ZSTD_SKIPPABLE_EN):
//   Skippable-frame magic 0x184D2A50..0x184D2A5F is accepted. The next four
//   bytes are read little-endian into fcs, header_len = 8, and the extra
//   output `skippable` is 1. When the macro is undefined the port is absent
//   and that magic is reported as a bad magic.
//
// Parameters
//   IN_BYTES     bytes per input beat (1, 2, 4 or 8)
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous reset, active-low
//   start        pulse: begin a new frame (honoured in IDLE/DONE/ERR only)
//   in_data      input beat; byte k at [8k+7:8k], byte 0 first in stream
//   in_valid     in_data valid
//   in_ready     parser accepts a beat (in_valid & in_ready = transfer)
//   done         header parsed and outputs valid; held until next start
//   err          parse failed; held until next start
//   err_code     0 none, 1 bad magic, 2 reserved FHD bit set
//   fhd          Frame_Header_Descriptor
//   window_desc  Window_Descriptor (0 when Single_Segment = 1)
//   dict_id      Dictionary_ID, zero-extended
//   fcs          Frame_Content_Size (a 2-byte field already has 256 added)
//   header_len   total header bytes including the magic (6..18)
//   lo_data      unconsumed bytes of the last beat, right-justified
//   lo_count     number of valid bytes in lo_data (0..IN_BYTES-1)
//   skippable    (ZSTD_SKIPPABLE_EN only) frame is a skippable frame
// ----------------------------------------------------------------------------
module zstd_frame_header_parser #(
    parameter int IN_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8*IN_BYTES-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            fhd,
    output logic [7:0]            window_desc,
    output logic [31:0]           dict_id,
    output logic [63:0]           fcs,
    output logic [4:0]            header_len,
    output logic [8*IN_BYTES-1:0] lo_data,
    output logic [3:0]            lo_count
`ifdef ZSTD_SKIPPABLE_EN
    ,
    output logic                  skippable
`endif
);

`ifdef ZSTD_SKIPPABLE_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAGIC,
        S_FHD,
        S_WD,
        S_DID,
        S_FCS,
        S_DONE,
        S_ERR
    } state_t;

    // ------------------------------------------------------------------
    // Field-size helpers, all derived from the descriptor byte
    // ------------------------------------------------------------------
    function automatic logic [7:0] std_magic_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'hB5;
            2'd2:    return 8'h2F;
            default: return 8'hFD;
        endcase
    endfunction

    // Skippable magic: 5X 2A 4D 18 (low nibble of the first byte is free).
    function automatic logic skp_magic_ok(input logic [1:0] i, input logic [7:0] b);
        logic ok;
        case (i)
            2'd0:    ok = (b[7:4] == 4'h5);
            2'd1:    ok = (b == 8'h2A);
            2'd2:    ok = (b == 8'h4D);
            default: ok = (b == 8'h18);
        endcase
        return SKIP_EN && ok;
    endfunction

    function automatic logic [3:0] did_size(input logic [1:0] flag);
        case (flag)
            2'd0:    return 4'd0;
            2'd1:    return 4'd1;
            2'd2:    return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] fcs_size(input logic [7:0] d);
        case (d[7:6])
            2'd0:    return d[5] ? 4'd1 : 4'd0;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic state_t after_did(input logic [7:0] d);
        return (fcs_size(d) != 4'd0) ? S_FCS : S_DONE;
    endfunction

    function automatic state_t after_wd(input logic [7:0] d);
        return (did_size(d[1:0]) != 4'd0) ? S_DID : after_did(d);
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t     state;
    logic [3:0] idx;        // byte index inside the current multi-byte field
    logic [4:0] byte_cnt;   // header bytes consumed so far
    logic       std_ok;     // magic bytes so far match the standard frame magic
    logic       skp_ok;     // magic bytes so far match the skippable magic
    logic       skip_mode;  // frame identified as skippable

    // ------------------------------------------------------------------
    // Byte walk over one beat: next values assuming the beat transfers
    // ------------------------------------------------------------------
    state_t                w_state;
    state_t                st_prev;
    logic [3:0]            w_idx;
    logic [4:0]            w_cnt;
    logic                  w_std;
    logic                  w_skp;
    logic                  w_skip;
    logic [7:0]            w_fhd;
    logic [7:0]            w_wd;
    logic [31:0]           w_did;
    logic [63:0]           w_fcs;
    logic [1:0]            w_err_code;
    logic [4:0]            w_hlen;
    logic [8*IN_BYTES-1:0] w_lo_data;
    logic [3:0]            w_lo_count;
    logic [3:0]            fcs_len;
    logic [7:0]            cur;

    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state    = state;
        st_prev    = state;
        w_idx      = idx;
        w_cnt      = byte_cnt;
        w_std      = std_ok;
        w_skp      = skp_ok;
        w_skip     = skip_mode;
        w_fhd      = fhd;
        w_wd       = window_desc;
        w_did      = dict_id;
        w_fcs      = fcs;
        w_err_code = err_code;
        w_hlen     = header_len;
        w_lo_data  = '0;
        w_lo_count = '0;
        fcs_len    = '0;
        cur        = '0;

        for (int k = 0; k < IN_BYTES; k++) begin
            cur     = in_data[8*k +: 8];
            st_prev = w_state;

            if (w_state inside {S_MAGIC, S_FHD, S_WD, S_DID, S_FCS}) begin
                w_cnt = w_cnt + 5'd1;
            end

            case (w_state)
                S_MAGIC: begin
                    // Both magics are tracked in parallel; the error fires on
                    // the first byte that matches neither.
                    w_std = w_std && (cur == std_magic_byte(w_idx[1:0]));
                    w_skp = w_skp && skp_magic_ok(w_idx[1:0], cur);
                    if (!w_std && !w_skp) begin
                        w_state    = S_ERR;
                        w_err_code = 2'd1;
                    end else if (w_idx == 4'd3) begin
                        w_idx = '0;
                        if (w_std) begin
                            w_state = S_FHD;
                        end else begin
                            // Skippable frame: the size field reuses the FCS walk.
                            w_state = S_FCS;
                            w_skip  = 1'b1;
                        end
                    end else begin
                        w_idx = w_idx + 4'd1;
                    end
                end

                S_FHD: begin
                    w_fhd = cur;
                    if (cur[3]) begin
                        w_state    = S_ERR;
                        w_err_code = 2'd2;
                    end else if (!cur[5]) begin
                        w_state = S_WD;
                    end else begin
                        w_state = after_wd(cur);
                    end
                end

                S_WD: begin
                    w_wd    = cur;
                    w_state = after_wd(w_fhd);
                end

                S_DID: begin
                    w_did[{w_idx[1:0], 3'b000} +: 8] = cur;
                    if (w_idx == did_size(w_fhd[1:0]) - 4'd1) begin
                        w_idx   = '0;
                        w_state = after_did(w_fhd);
                    end else begin
                        w_idx = w_idx + 4'd1;
                    end
                end

                S_FCS: begin
                    fcs_len = w_skip ? 4'd4 : fcs_size(w_fhd);
                    w_fcs[{w_idx[2:0], 3'b000} +: 8] = cur;
                    if (w_idx == fcs_len - 4'd1) begin
                        w_idx = '0;
                        // The 2-byte encoding stores size-256.
                        if (!w_skip && fcs_len == 4'd2) begin
                            w_fcs = w_fcs + 64'd256;
                        end
                        w_state = S_DONE;
                    end else begin
                        w_idx = w_idx + 4'd1;
                    end
                end

                default: ;
            endcase

            // Header finished on byte k: the rest of the beat is left over.
            if (st_prev != S_DONE && w_state == S_DONE) begin
                w_hlen     = w_cnt;
                w_lo_count = 4'(IN_BYTES - 1 - k);
                w_lo_data  = in_data >> (8 * (k + 1));
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            byte_cnt    <= '0;
            std_ok      <= 1'b0;
            skp_ok      <= 1'b0;
            skip_mode   <= 1'b0;
            in_ready    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            fhd         <= '0;
            window_desc <= '0;
            dict_id     <= '0;
            fcs         <= '0;
            header_len  <= '0;
            lo_data     <= '0;
            lo_count    <= '0;
        end else if (start && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
            state       <= S_MAGIC;
            idx         <= '0;
            byte_cnt    <= '0;
            std_ok      <= 1'b1;
            skp_ok      <= SKIP_EN;
            skip_mode   <= 1'b0;
            in_ready    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            fhd         <= '0;
            window_desc <= '0;
            dict_id     <= '0;
            fcs         <= '0;
            header_len  <= '0;
            lo_data     <= '0;
            lo_count    <= '0;
        end else if (in_valid && in_ready) begin
            state       <= w_state;
            idx         <= w_idx;
            byte_cnt    <= w_cnt;
            std_ok      <= w_std;
            skp_ok      <= w_skp;
            skip_mode   <= w_skip;
            fhd         <= w_fhd;
            window_desc <= w_wd;
            dict_id     <= w_did;
            fcs         <= w_fcs;
            if (w_state == S_DONE) begin
                done       <= 1'b1;
                in_ready   <= 1'b0;
                header_len <= w_hlen;
                lo_data    <= w_lo_data;
                lo_count   <= w_lo_count;
            end
            if (w_state == S_ERR) begin
                err      <= 1'b1;
                err_code <= w_err_code;
                in_ready <= 1'b0;
            end
        end
    end

`ifdef ZSTD_SKIPPABLE_EN
    assign skippable = done & skip_mode;
`endif

endmodule

// File: tb/tb_zstd_frame_header_parser.sv
// ----------------------------------------------------------------------------
// tb_zstd_frame_header_parser
//
// Self-checking bench for zstd_frame_header_parser with IN_BYTES = 2.
// Expected results come from a byte-position reference model that reads the
// header straight from the frame-format rules. Stimulus mixes the directed
// frames with randomized headers, corrupted magics, reserved-bit
// descriptors and random in_valid stalls.
// ----------------------------------------------------------------------------
module tb_zstd_frame_header_parser;

    localparam int NB = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [8*NB-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            done;
    logic            err;
    logic [1:0]      err_code;
    logic [7:0]      fhd;
    logic [7:0]      window_desc;
    logic [31:0]     dict_id;
    logic [63:0]     fcs;
    logic [4:0]      header_len;
    logic [8*NB-1:0] lo_data;
    logic [3:0]      lo_count;
`ifdef ZSTD_SKIPPABLE_EN
    logic            skippable;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    zstd_frame_header_parser #(.IN_BYTES(NB)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .fhd         (fhd),
        .window_desc (window_desc),
        .dict_id     (dict_id),
        .fcs         (fcs),
        .header_len  (header_len),
        .lo_data     (lo_data),
        .lo_count    (lo_count)
`ifdef ZSTD_SKIPPABLE_EN
        ,
        .skippable   (skippable)
`endif
    );

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic            done;
        logic            err;
        logic [1:0]      code;
        logic [7:0]      fhd;
        logic [7:0]      wd;
        logic [31:0]     did;
        logic [63:0]     fcs;
        logic [4:0]      hl;
        logic [8*NB-1:0] lo;
        logic [3:0]      lc;
        int              beats;   // beats that must transfer before done/err
    } exp_t;

    // ------------------------------------------------------------------
    // Reference model: walks byte positions of the header directly
    // ------------------------------------------------------------------
    function automatic exp_t model(input bq_t b);
        exp_t       e;
        int         pos;
        int         wdl;
        int         didl;
        int         fcsl;
        logic [7:0] d;
        logic [7:0] magic [4];
        magic = '{8'h28, 8'hB5, 8'h2F, 8'hFD};
        e = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            if (b[i] !== magic[i]) begin
                e.err   = 1'b1;
                e.code  = 2'd1;
                e.beats = i / NB + 1;
                return e;
            end
        end
        d     = b[4];
        e.fhd = d;
        if (d[3]) begin
            e.err   = 1'b1;
            e.code  = 2'd2;
            e.beats = 4 / NB + 1;
            return e;
        end
        wdl = d[5] ? 0 : 1;
        case (d[1:0])
            2'd0:    didl = 0;
            2'd1:    didl = 1;
            2'd2:    didl = 2;
            default: didl = 4;
        endcase
        case (d[7:6])
            2'd0:    fcsl = d[5] ? 1 : 0;
            2'd1:    fcsl = 2;
            2'd2:    fcsl = 4;
            default: fcsl = 8;
        endcase
        pos = 5;
        if (wdl == 1) e.wd = b[pos];
        pos += wdl;
        for (int i = 0; i < didl; i++) e.did += 32'(b[pos + i]) << (8 * i);
        pos += didl;
        for (int i = 0; i < fcsl; i++) e.fcs += 64'(b[pos + i]) << (8 * i);
        pos += fcsl;
        if (fcsl == 2) e.fcs += 64'd256;
        e.done  = 1'b1;
        e.hl    = 5'(pos);
        e.beats = (pos + NB - 1) / NB;
        e.lc    = 4'((NB - pos % NB) % NB);
        for (int i = 0; i < int'(e.lc); i++) e.lo[8*i +: 8] = b[pos + i];
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Drive one frame and compare every output with the model
    // ------------------------------------------------------------------
    task automatic run_frame(input bq_t b, input string name, input int stall_pct,
                             input int lead_stall, input bit poke_start);
        exp_t e;
        int   bi;
        int   cyc;
        bit   xf;
        bit   poked;
        int   p;
        e     = model(b);
        bi    = 0;
        cyc   = 0;
        poked = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1 || header_len !== 5'd0) begin
            bad++;
            $display("FAIL %s start_clear: done=%b err=%b in_ready=%b hlen=%0d want 0 0 1 0",
                     name, done, err, in_ready, header_len);
        end

        while (!(done || err) && cyc < 300) begin
            for (int j = 0; j < NB; j++) begin
                p = bi * NB + j;
                in_data[8*j +: 8] = (p < b.size()) ? b[p] : 8'h00;
            end
            in_valid = (cyc < lead_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            if (poke_start && bi == 1 && !poked) begin
                start    = 1'b1;   // must be ignored while parsing
                in_valid = 1'b0;
                poked    = 1'b1;
            end
            xf = in_valid && in_ready;
            @(negedge clk);
            start = 1'b0;
            if (xf) bi++;
            cyc++;
        end
        in_valid = 1'b0;

        total++;
        if (!(done || err)) begin
            bad++;
            $display("FAIL %s timeout: no done/err after %0d cycles", name, cyc);
            return;
        end

        total++;
        if (bi !== e.beats) begin
            bad++;
            $display("FAIL %s beats: got=%0d want=%0d", name, bi, e.beats);
        end
        total++;
        if (done !== e.done || err !== e.err || err_code !== e.code) begin
            bad++;
            $display("FAIL %s status: done=%b err=%b code=%0d want %b %b %0d",
                     name, done, err, err_code, e.done, e.err, e.code);
        end
        total++;
        if (fhd !== e.fhd) begin
            bad++;
            $display("FAIL %s fhd: got=%h want=%h", name, fhd, e.fhd);
        end
        total++;
        if (window_desc !== e.wd) begin
            bad++;
            $display("FAIL %s window_desc: got=%h want=%h", name, window_desc, e.wd);
        end
        total++;
        if (dict_id !== e.did) begin
            bad++;
            $display("FAIL %s dict_id: got=%h want=%h", name, dict_id, e.did);
        end
        total++;
        if (fcs !== e.fcs) begin
            bad++;
            $display("FAIL %s fcs: got=%h want=%h", name, fcs, e.fcs);
        end
        total++;
        if (header_len !== e.hl) begin
            bad++;
            $display("FAIL %s header_len: got=%0d want=%0d", name, header_len, e.hl);
        end
        total++;
        if (lo_count !== e.lc || lo_data !== e.lo) begin
            bad++;
            $display("FAIL %s leftover: cnt=%0d data=%h want %0d %h", name, lo_count, lo_data, e.lc, e.lo);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s in_ready_drop: got=%b want=0", name, in_ready);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, done, err, err_code, fhd, window_desc, dict_id, fcs,
             header_len, lo_data, lo_count} !== '0) begin
            bad++;
            $display("FAIL reset_state: outputs not all zero (in_ready=%b done=%b err=%b)",
                     in_ready, done, err);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bq_t q;
        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h24, 8'h0D, 8'h00, 8'h00};
        run_frame(q, "ex_single_seg", 0, 0, 1'b0);
        total++;
        if (fhd !== 8'h24 || fcs !== 64'h0D || header_len !== 5'd6 || lo_count !== 4'd0) begin
            bad++;
            $display("FAIL ex_single_seg const: fhd=%h fcs=%h hlen=%0d lo=%0d want 24 0d 6 0",
                     fhd, fcs, header_len, lo_count);
        end

        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h40, 8'h58, 8'h34, 8'h12, 8'h00, 8'h00};
        run_frame(q, "ex_fcs2", 0, 0, 1'b0);
        total++;
        if (window_desc !== 8'h58 || fcs !== 64'h1334 || header_len !== 5'd8) begin
            bad++;
            $display("FAIL ex_fcs2 const: wd=%h fcs=%h hlen=%0d want 58 1334 8",
                     window_desc, fcs, header_len);
        end

        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h03, 8'h58, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        run_frame(q, "ex_did4", 0, 0, 1'b1);
        total++;
        if (dict_id !== 32'h44332211 || fcs !== 64'h0 || header_len !== 5'd10) begin
            bad++;
            $display("FAIL ex_did4 const: did=%h fcs=%h hlen=%0d want 44332211 0 10",
                     dict_id, fcs, header_len);
        end

        // Odd header length leaves one spare byte in the last beat.
        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h21, 8'h7E, 8'h99, 8'hC3, 8'h00};
        run_frame(q, "odd_len", 0, 0, 1'b0);
        total++;
        if (lo_count !== 4'd1 || lo_data !== 16'h00C3 || header_len !== 5'd7) begin
            bad++;
            $display("FAIL odd_len const: lo_cnt=%0d lo=%h hlen=%0d want 1 00c3 7",
                     lo_count, lo_data, header_len);
        end

        q = '{8'h29, 8'hB5, 8'h2F, 8'hFD, 8'h00, 8'h00};
        run_frame(q, "bad_magic", 0, 0, 1'b0);
        total++;
        if (err !== 1'b1 || err_code !== 2'd1 || done !== 1'b0) begin
            bad++;
            $display("FAIL bad_magic const: err=%b code=%0d done=%b want 1 1 0", err, err_code, done);
        end

        // The start check at the head of this frame confirms err is cleared.
        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h08, 8'h00};
        run_frame(q, "reserved_bit", 0, 0, 1'b0);
        total++;
        if (err_code !== 2'd2) begin
            bad++;
            $display("FAIL reserved_bit const: code=%0d want 2", err_code);
        end
    endtask

    task automatic test_reset_midparse();
        bq_t q;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_data  = 16'hB528;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        total++;
        if ({in_ready, done, err, err_code, fhd, dict_id, fcs, header_len} !== '0) begin
            bad++;
            $display("FAIL reset_midparse: in_ready=%b done=%b err=%b not cleared", in_ready, done, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        q = '{8'h28, 8'hB5, 8'h2F, 8'hFD, 8'h62, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        run_frame(q, "restart_stall", 0, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        bq_t   q;
        string nm;
        for (int n = 0; n < 40; n++) begin
            q = {};
            q.push_back(8'h28);
            q.push_back(8'hB5);
            q.push_back(8'h2F);
            q.push_back(8'hFD);
            q.push_back(8'($urandom));
            if ($urandom_range(9) != 0) q[4][3] = 1'b0;
            for (int i = 0; i < 18; i++) q.push_back(8'($urandom));
            if ($urandom_range(9) == 0) begin
                int k;
                k    = $urandom_range(3);
                q[k] = q[k] ^ 8'($urandom_range(255, 1));
            end
            nm = $sformatf("rand%0d", n);
            run_frame(q, nm, 30, 0, 1'b0);
        end
    endtask

`ifdef ZSTD_SKIPPABLE_EN
    task automatic test_skippable();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int bt = 0; bt < 4; bt++) begin
            case (bt)
                0:       in_data = 16'h2A53;
                1:       in_data = 16'h184D;
                2:       in_data = 16'h0010;
                default: in_data = 16'h0000;
            endcase
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        total++;
        if (skippable !== 1'b1 || done !== 1'b1 || fcs !== 64'h10 || header_len !== 5'd8 || fhd !== 8'h00) begin
            bad++;
            $display("FAIL skippable: skp=%b done=%b fcs=%h hlen=%0d fhd=%h want 1 1 10 8 00",
                     skippable, done, fcs, header_len, fhd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_midparse();
        test_back_to_back();
`ifdef ZSTD_SKIPPABLE_EN
        test_skippable();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
